// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address / strobe sequencer for an in-place radix-2 DIT FFT.
// Issues one butterfly per cycle over a dual-port sample RAM. It generates the read
// addresses, the twiddle ROM index and the operand-valid strobe. It also produces
// write-back addresses delayed by the read latency plus the butterfly latency.
// Optional feature macro: FFT_STAGE_SCALE_EN. When it is defined, scale_o requests
// a per-stage halving in the butterfly.
//
// state | meaning
// IDLE  | waiting for start_i; stage index held at 0
// RUN   | one butterfly issued per cycle, k = 0..N/2-1
// DRAIN | reads paused until the last write of the stage has committed
// DONE  | one-cycle completion pulse

module fft_stage_sequencer #(
  parameter int N_LOG2     = 9,
  parameter int BF_LATENCY = 3,
  parameter int ADDR_W     = N_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] stage_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [N_LOG2-2:0] tw_addr_o,
  output logic              bf_valid_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o,
  output logic              scale_o
);

  localparam int PIPE = 1 + BF_LATENCY;
  localparam int KW   = N_LOG2 - 1;
  localparam int DW   = $clog2(PIPE + 1);

  localparam logic [KW-1:0]     K_LAST = '1;
  localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(N_LOG2 - 1);
  localparam logic [DW-1:0]     D_LOAD = DW'(PIPE);
  localparam logic [DW-1:0]     D_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic              run;

  // State, stage, butterfly and drain-timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          dcnt_d  = D_LOAD;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == D_ONE) begin
          dcnt_d = '0;
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + ADDR_W'(1);
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q - D_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign run     = (state_q == RUN);
  assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
  assign done_o  = (state_q == DONE);
  assign rd_en_o = run;
  assign stage_o = s_q;

  logic [ADDR_W-1:0] k_ext, span, pos, grp, addr_a, tw_full;

  // Butterfly leg addresses and twiddle index from (stage, k)
  always_comb begin
    k_ext   = ADDR_W'(k_q);
    span    = ADDR_W'(1) << s_q;
    pos     = k_ext & (span - ADDR_W'(1));
    grp     = k_ext >> s_q;
    addr_a  = (grp << (s_q + ADDR_W'(1))) | pos;
    tw_full = pos << (S_LAST - s_q);
  end

  // Addresses are forced to zero outside RUN so idle buses stay quiet
  assign rd_addr_a_o = run ? addr_a : '0;
  assign rd_addr_b_o = run ? (addr_a + span) : '0;
  assign tw_addr_o   = run ? tw_full[KW-1:0] : '0;

  logic [PIPE-1:0]   en_d;
  logic [ADDR_W-1:0] wa_d [PIPE];
  logic [ADDR_W-1:0] wb_d [PIPE];

  // Write-back delay line; cleared by reset so an aborted transform never writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d <= '0;
      for (int i = 0; i < PIPE; i++) begin
        wa_d[i] <= '0;
        wb_d[i] <= '0;
      end
    end else begin
      en_d[0] <= run;
      wa_d[0] <= rd_addr_a_o;
      wb_d[0] <= rd_addr_b_o;
      for (int i = 1; i < PIPE; i++) begin
        en_d[i] <= en_d[i-1];
        wa_d[i] <= wa_d[i-1];
        wb_d[i] <= wb_d[i-1];
      end
    end
  end

  assign bf_valid_o  = en_d[0];
  assign wr_en_o     = en_d[PIPE-1];
  assign wr_addr_a_o = wa_d[PIPE-1];
  assign wr_addr_b_o = wb_d[PIPE-1];

`ifdef FFT_STAGE_SCALE_EN
  assign scale_o = bf_valid_o;
`else
  assign scale_o = 1'b0;
`endif

endmodule
